// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, reset PC and fetch FSM states.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned JIDX_W  = 26;

    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_next_pc_calc.sv
// Next-PC arithmetic: sequential PC+4 and the redirect target (jump beats branch).
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] pc,
    input  logic [INSTR_W-1:0] id_pc4,
    input  logic [INSTR_W-1:0] sext_imm,
    input  logic [JIDX_W-1:0]  jidx,
    input  logic               jump,
    input  logic               branch_taken,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic [INSTR_W-1:0] target
);

    logic [INSTR_W-1:0] br_target;
    logic [INSTR_W-1:0] j_target;

    // Both targets are computed in parallel; jump selects over branch.
    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_target = id_pc4 + (sext_imm << 2);
        j_target  = {id_pc4[INSTR_W-1:INSTR_W-4], jidx, 2'b00};
        target    = pc_plus4;
        if (jump) begin
            target = j_target;
        end else if (branch_taken) begin
            target = br_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and the IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic [INSTR_W-1:0] sext_imm,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [INSTR_W-1:0] id_pc4,
    output logic [IMM_W-1:0]   id_imm16
);

    fetch_state_t       state, state_n;
    logic               live;
    logic [INSTR_W-1:0] pc, pc_n;
    logic [INSTR_W-1:0] skid, skid_n;
    logic [INSTR_W-1:0] held_addr, held_n;
    logic               valid_n;
    logic [INSTR_W-1:0] instr_n, pc4_n;
    logic [INSTR_W-1:0] pc_plus4, target;
    logic               redirect;

    assign id_imm16 = id_instr[IMM_W-1:0];
    assign redirect = id_valid & ~stall & (jump | branch_taken);

    next_pc_calc u_next_pc (
        .pc           (pc),
        .id_pc4       (id_pc4),
        .sext_imm     (sext_imm),
        .jidx         (id_instr[JIDX_W-1:0]),
        .jump         (jump),
        .branch_taken (branch_taken),
        .pc_plus4     (pc_plus4),
        .target       (target)
    );

    // State, PC and IF/ID registers; live stays low for the first cycle after reset
    // so no request is raised and no in-flight ack is taken before then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            live      <= 1'b0;
            pc        <= RESET_PC;
            skid      <= '0;
            held_addr <= '0;
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_pc4    <= '0;
        end else begin
            state     <= state_n;
            live      <= 1'b1;
            pc        <= pc_n;
            skid      <= skid_n;
            held_addr <= held_n;
            id_valid  <= valid_n;
            id_instr  <= instr_n;
            id_pc4    <= pc4_n;
        end
    end

    // Next-state, next-PC, IF/ID update and handshake outputs.
    // DROP keeps presenting the pre-redirect address (held_addr) while pc already holds the target.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        skid_n    = skid;
        held_n    = held_addr;
        valid_n   = id_valid;
        instr_n   = id_instr;
        pc4_n     = id_pc4;
        imem_req  = 1'b0;
        imem_addr = pc;
        if (live) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (redirect) begin
                            pc_n    = target;
                            valid_n = 1'b0;
                        end else if (!stall) begin
                            instr_n = imem_rdata;
                            pc4_n   = pc_plus4;
                            valid_n = 1'b1;
                            pc_n    = pc_plus4;
                        end else begin
                            skid_n  = imem_rdata;
                            state_n = HOLD;
                        end
                    end else if (redirect) begin
                        pc_n    = target;
                        held_n  = pc;
                        valid_n = 1'b0;
                        state_n = DROP;
                    end else if (!stall) begin
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_n    = target;
                        valid_n = 1'b0;
                        state_n = FETCH;
                    end else if (!stall) begin
                        instr_n = skid;
                        pc4_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                        state_n = FETCH;
                    end
                end
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = held_addr;
                    if (!stall) begin
                        valid_n = 1'b0;
                    end
                    if (imem_ack) begin
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a transaction-level model of the expected instruction stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_hi = 1'b0;
    logic        imem_req, imem_ack = 1'b0, id_valid;
    logic [31:0] imem_addr, imem_rdata, sext_imm, id_instr, id_pc4;
    logic [15:0] id_imm16;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic        force_en = 1'b0;
    logic [31:0] force_data = '0;

    logic        req_hi, ack_hi = 1'b0, valid_hi;
    logic [31:0] addr_hi, rdata_hi, sext_hi, instr_hi, pc4_hi;
    logic [15:0] imm16_hi;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: a few placed instructions, hashed words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h1000_0010;
            32'h0000_001C: return 32'h1000_FFFC;
            32'h0000_0024: return 32'h1000_FFF5;
            32'h9000_0000: return 32'h0800_0040;
            default:       return a * 32'h9E37_79B9 + 32'h1234_5677;
        endcase
    endfunction

    assign imem_rdata = force_en ? force_data : mem_word(imem_addr);
    assign sext_imm   = {{16{id_imm16[15]}}, id_imm16};
    assign rdata_hi   = mem_word(addr_hi);
    assign sext_hi    = {{16{imm16_hi[15]}}, imm16_hi};

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .sext_imm(sext_imm),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4), .id_imm16(id_imm16)
    );

    fetch_stage #(.RESET_PC(32'h9000_0000)) dut_hi (
        .clk(clk), .rst_n(rst_n_hi), .imem_req(req_hi), .imem_addr(addr_hi),
        .imem_ack(ack_hi), .imem_rdata(rdata_hi), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .sext_imm(sext_hi),
        .id_valid(valid_hi), .id_instr(instr_hi), .id_pc4(pc4_hi), .id_imm16(imm16_hi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h want=0", id_instr); end
        checks++; if (id_pc4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h want=0", id_pc4); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_release_req got=%b want=0", imem_req); end
    endtask

    task automatic test_straight_line();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin failures++; $display("FAIL sl_addr%0d got=%b/%h want=1/%h", i, imem_req, imem_addr, 4 * i); end
            step();
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL sl_valid%0d got=%b want=1", i, id_valid); end
            checks++; if (id_pc4 !== 32'(4 * i + 4)) begin failures++; $display("FAIL sl_pc4%0d got=%h want=%h", i, id_pc4, 4 * i + 4); end
            checks++; if (id_instr !== mem_word(32'(4 * i))) begin failures++; $display("FAIL sl_instr%0d got=%h want=%h", i, id_instr, mem_word(32'(4 * i))); end
        end
    endtask

    task automatic wait_pc4(input logic [31:0] want, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (id_valid && id_pc4 == want) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin failures++; $display("FAIL %s_reach got=%h want=%h", name, id_pc4, want); end
    endtask

    task automatic test_backward_branch();
        wait_pc4(32'h20, "bb");
        // instr at 0x1C has imm16 FFFC: 0x20 + (-4 << 2) = 0x10
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL bb_addr got=%h want=00000010", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL bb_bubble got=%b want=0", id_valid); end
        step();
        checks++; if ({id_valid, id_pc4} !== {1'b1, 32'h14}) begin failures++; $display("FAIL bb_resume got=%b/%h want=1/00000014", id_valid, id_pc4); end
    endtask

    task automatic test_wrap();
        wait_pc4(32'h28, "wrap");
        // instr at 0x24 has imm16 FFF5: 0x28 + (-11 << 2) = 0xFFFF_FFFC
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
        step();
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h want=0", imem_addr); end
        checks++; if ({id_valid, id_pc4} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wrap_pc4 got=%b/%h want=1/0", id_valid, id_pc4); end
        checks++; if (id_instr !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_instr got=%h want=%h", id_instr, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic test_stall_ack();
        logic [31:0] a, s_instr, s_pc4;
        logic        s_valid;
        a = imem_addr; s_instr = id_instr; s_pc4 = id_pc4; s_valid = id_valid;
        stall = 1'b1; imem_ack = 1'b1; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            force_en = 1'b0;
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req%0d got=%b want=0", i, imem_req); end
            checks++; if ({id_valid, id_instr, id_pc4} !== {s_valid, s_instr, s_pc4}) begin failures++; $display("FAIL hold_ifid%0d got=%b/%h/%h want=%b/%h/%h", i, id_valid, id_instr, id_pc4, s_valid, s_instr, s_pc4); end
        end
        stall = 1'b0;
        step();
        checks++; if ({id_valid, id_instr} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL release_instr got=%b/%h want=1/deadbeef", id_valid, id_instr); end
        checks++; if (id_pc4 !== a + 32'd4) begin failures++; $display("FAIL release_pc4 got=%h want=%h", id_pc4, a + 32'd4); end
        checks++; if ({imem_req, imem_addr} !== {1'b1, a + 32'd4}) begin failures++; $display("FAIL release_nodup got=%b/%h want=1/%h", imem_req, imem_addr, a + 32'd4); end
    endtask

    task automatic test_drop();
        logic [31:0] old;
        step();
        // ID now holds instr at 0x4 (imm16 0x0010): target = 0x8 + 0x40 = 0x48
        old = imem_addr;
        imem_ack = 1'b0; branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL drop_bubble got=%b want=0", id_valid); end
        for (int i = 0; i < 2; i++) begin
            checks++; if ({imem_req, imem_addr} !== {1'b1, old}) begin failures++; $display("FAIL drop_hold%0d got=%b/%h want=1/%h", i, imem_req, imem_addr, old); end
            step();
        end
        checks++; if ({imem_req, imem_addr} !== {1'b1, old}) begin failures++; $display("FAIL drop_hold2 got=%b/%h want=1/%h", imem_req, imem_addr, old); end
        imem_ack = 1'b1; force_en = 1'b1; force_data = 32'hBAD0_BAD0;
        step();
        force_en = 1'b0;
        checks++; if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h48, 1'b0}) begin failures++; $display("FAIL drop_target got=%b/%h/%b want=1/00000048/0", imem_req, imem_addr, id_valid); end
        step();
        checks++; if ({id_valid, id_pc4, id_instr} !== {1'b1, 32'h4C, mem_word(32'h48)}) begin failures++; $display("FAIL drop_resume got=%b/%h/%h want=1/0000004c/%h", id_valid, id_pc4, id_instr, mem_word(32'h48)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, m_pc4, m_instr, tgt, p_addr, p_instr, p_pc4;
        logic        p_valid, p_req, p_ack, redir;
        int          off;
        int          deliveries = 0;
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_pc = 32'h0; m_pc4 = '0; m_instr = '0; tgt = '0;
        for (int c = 0; c < 400; c++) begin
            p_valid = id_valid; p_instr = id_instr; p_pc4 = id_pc4;
            p_req = imem_req; p_addr = imem_addr;
            stall        = ($urandom_range(3) == 0);
            imem_ack     = ($urandom_range(2) != 0);
            branch_taken = ($urandom_range(5) == 0);
            jump         = ($urandom_range(9) == 0);
            p_ack = imem_ack;
            redir = p_valid && !stall && (jump || branch_taken);
            if (redir) begin
                off = $signed(m_instr[15:0]);
                tgt = jump ? {m_pc4[31:28], m_instr[25:0], 2'b00} : m_pc4 + 32'(off * 4);
            end
            step();
            if (stall) begin
                checks++; if ({id_valid, id_instr, id_pc4} !== {p_valid, p_instr, p_pc4}) begin failures++; $display("FAIL rnd_stall c=%0d got=%b/%h/%h want=%b/%h/%h", c, id_valid, id_instr, id_pc4, p_valid, p_instr, p_pc4); end
            end else if (redir) begin
                checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rnd_bubble c=%0d got=%b want=0", c, id_valid); end
                exp_pc = tgt;
            end else if (id_valid) begin
                checks++; if ({id_pc4, id_instr} !== {exp_pc + 32'd4, mem_word(exp_pc)}) begin failures++; $display("FAIL rnd_deliver c=%0d got=%h/%h want=%h/%h", c, id_pc4, id_instr, exp_pc + 32'd4, mem_word(exp_pc)); end
                m_pc4 = exp_pc + 32'd4; m_instr = mem_word(exp_pc);
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (p_req && !p_ack) begin
                checks++; if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin failures++; $display("FAIL rnd_handshake c=%0d got=%b/%h want=1/%h", c, imem_req, imem_addr, p_addr); end
            end
        end
        checks++; if (deliveries < 40) begin failures++; $display("FAIL rnd_progress got=%0d want>=40", deliveries); end
        stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic test_jump();
        rst_n = 1'b0; rst_n_hi = 1'b1; ack_hi = 1'b1;
        step();
        checks++; if ({req_hi, addr_hi} !== {1'b1, 32'h9000_0000}) begin failures++; $display("FAIL jmp_first got=%b/%h want=1/90000000", req_hi, addr_hi); end
        step();
        checks++; if ({valid_hi, pc4_hi} !== {1'b1, 32'h9000_0004}) begin failures++; $display("FAIL jmp_id got=%b/%h want=1/90000004", valid_hi, pc4_hi); end
        jump = 1'b1; branch_taken = 1'b1;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        checks++; if ({addr_hi, valid_hi} !== {32'h9000_0100, 1'b0}) begin failures++; $display("FAIL jmp_target got=%h/%b want=90000100/0", addr_hi, valid_hi); end
        step();
        checks++; if ({valid_hi, pc4_hi} !== {1'b1, 32'h9000_0104}) begin failures++; $display("FAIL jmp_resume got=%b/%h want=1/90000104", valid_hi, pc4_hi); end
        rst_n_hi = 1'b0; ack_hi = 1'b0;
    endtask

    task automatic test_async_reset();
        rst_n = 1'b1; imem_ack = 1'b1;
        step(); step(); step();
        imem_ack = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({imem_req, id_valid, id_instr, id_pc4} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL arst_zero got=%b/%b/%h/%h want=0/0/0/0", imem_req, id_valid, id_instr, id_pc4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL arst_addr got=%h want=0", imem_addr); end
        imem_ack = 1'b1;
        #3;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL arst_idle got=%b want=0", imem_req); end
        step();
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL arst_restart got=%b/%h want=1/0", imem_req, imem_addr); end
        step();
        checks++; if ({id_valid, id_pc4, id_instr} !== {1'b1, 32'h4, mem_word(32'h0)}) begin failures++; $display("FAIL arst_first got=%b/%h/%h want=1/4/%h", id_valid, id_pc4, id_instr, mem_word(32'h0)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_straight_line();
        test_backward_branch();
        test_wrap();
        test_stall_ack();
        test_drop();
        test_random();
        test_jump();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
